march_bist_sequencer: RTL

March C- memory BIST sequencer for a single-port RAM under test. On `start` it walks the full address space through the six March C- elements, drives read/write strobes, address and write data to the RAM, and compares read data against the expected background. It reports `done` plus a sticky `fail` with the first failing address and element. It replaces hand-sequenced W0/R0/W1/R1 passes with one self-contained engine that owns its own address counter.

---
 rtl/march_bist_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/march_bist_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | march_bist_sequencer                                                       |
// | March C- BIST engine: sequences a single-port RAM, records first miscompare|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module march_bist_sequencer #(
    parameter int A_WIDTH = 4,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [D_WIDTH-1:0] mem_rdata,
    output logic [A_WIDTH-1:0] mem_addr,
    output logic [D_WIDTH-1:0] mem_wdata,
    output logic               mem_we,
    output logic               mem_re,
    output logic               busy,
    output logic               done,
    output logic               fail,
    output logic [A_WIDTH-1:0] fail_addr,
    output logic [2:0]         fail_elem
);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        M0_W  = 4'd1,
        M1_R  = 4'd2,
        M1_W  = 4'd3,
        M2_R  = 4'd4,
        M2_W  = 4'd5,
        M3_R  = 4'd6,
        M3_W  = 4'd7,
        M4_R  = 4'd8,
        M4_W  = 4'd9,
        M5_R  = 4'd10,
        DRAIN = 4'd11,
        DONE  = 4'd12
    } state_t;

    localparam logic [A_WIDTH-1:0] c_addr_last = {A_WIDTH{1'b1}};
    localparam logic [A_WIDTH-1:0] c_addr_one  = A_WIDTH'(1);
    localparam logic [D_WIDTH-1:0] c_bg_one    = {D_WIDTH{1'b1}};

    state_t               r_state;
    state_t               w_next_state;
    logic [A_WIDTH-1:0]   w_next_addr;
    logic                 w_accept;
    logic                 w_next_we;
    logic                 w_next_re;
    logic [D_WIDTH-1:0]   w_next_wdata;
    logic [D_WIDTH-1:0]   w_rd_exp;
    logic [2:0]           w_rd_elem;

    logic                 r_pend_v;
    logic [D_WIDTH-1:0]   r_pend_exp;
    logic [2:0]           r_pend_elem;
    logic [A_WIDTH-1:0]   r_pend_addr;

    assign w_accept = ((r_state == IDLE) || (r_state == DONE)) && start;

    // Next op: the registered strobes/address always describe the op of the state being entered.
    always_comb begin
        w_next_state = r_state;
        w_next_addr  = mem_addr;
        case (r_state)
            IDLE, DONE: if (start) begin
                w_next_state = M0_W;
                w_next_addr  = '0;
            end
            M0_W: if (mem_addr == c_addr_last) begin
                w_next_state = M1_R;
                w_next_addr  = '0;
            end else begin
                w_next_addr  = mem_addr + c_addr_one;
            end
            M1_R: w_next_state = M1_W;
            M1_W: if (mem_addr == c_addr_last) begin
                w_next_state = M2_R;
                w_next_addr  = '0;
            end else begin
                w_next_state = M1_R;
                w_next_addr  = mem_addr + c_addr_one;
            end
            M2_R: w_next_state = M2_W;
            M2_W: if (mem_addr == c_addr_last) begin
                w_next_state = M3_R;
                w_next_addr  = c_addr_last;
            end else begin
                w_next_state = M2_R;
                w_next_addr  = mem_addr + c_addr_one;
            end
            M3_R: w_next_state = M3_W;
            M3_W: if (mem_addr == '0) begin
                w_next_state = M4_R;
                w_next_addr  = c_addr_last;
            end else begin
                w_next_state = M3_R;
                w_next_addr  = mem_addr - c_addr_one;
            end
            M4_R: w_next_state = M4_W;
            M4_W: if (mem_addr == '0) begin
                w_next_state = M5_R;
                w_next_addr  = c_addr_last;
            end else begin
                w_next_state = M4_R;
                w_next_addr  = mem_addr - c_addr_one;
            end
            M5_R: if (mem_addr == '0) begin
                w_next_state = DRAIN;
            end else begin
                w_next_addr  = mem_addr - c_addr_one;
            end
            DRAIN:   w_next_state = DONE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_next_we    = 1'b0;
        w_next_re    = 1'b0;
        w_next_wdata = '0;
        case (w_next_state)
            M0_W, M2_W, M4_W: w_next_we = 1'b1;
            M1_W, M3_W: begin
                w_next_we    = 1'b1;
                w_next_wdata = c_bg_one;
            end
            M1_R, M2_R, M3_R, M4_R, M5_R: w_next_re = 1'b1;
            default: ;
        endcase
    end

    // Expected background and element tag of the read currently on the bus.
    always_comb begin
        w_rd_exp  = '0;
        w_rd_elem = 3'd0;
        case (r_state)
            M1_R: w_rd_elem = 3'd1;
            M2_R: begin
                w_rd_exp  = c_bg_one;
                w_rd_elem = 3'd2;
            end
            M3_R: w_rd_elem = 3'd3;
            M4_R: begin
                w_rd_exp  = c_bg_one;
                w_rd_elem = 3'd4;
            end
            M5_R: w_rd_elem = 3'd5;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            mem_addr  <= w_next_addr;
            mem_wdata <= w_next_wdata;
            mem_we    <= w_next_we;
            mem_re    <= w_next_re;
            busy      <= (w_next_state != IDLE) && (w_next_state != DONE);
            done      <= (w_next_state == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend_v    <= 1'b0;
            r_pend_exp  <= '0;
            r_pend_elem <= 3'd0;
            r_pend_addr <= '0;
            fail        <= 1'b0;
            fail_addr   <= '0;
            fail_elem   <= 3'd0;
        end else begin
            r_pend_v    <= mem_re;
            r_pend_exp  <= w_rd_exp;
            r_pend_elem <= w_rd_elem;
            r_pend_addr <= mem_addr;
            if (w_accept) begin
                fail      <= 1'b0;
                fail_addr <= '0;
                fail_elem <= 3'd0;
            end else if (r_pend_v && (mem_rdata != r_pend_exp) && !fail) begin
                fail      <= 1'b1;
                fail_addr <= r_pend_addr;
                fail_elem <= r_pend_elem;
            end
        end
    end

endmodule
`default_nettype wire
